// File: rtl/parking_pkg.sv
// Shared definitions for the parking lane controller: state encoding,
// beam sensor codes and the default lot capacity.
package parking_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_EN1   = 3'd1;
  localparam state_t ST_EN2   = 3'd2;
  localparam state_t ST_EN3   = 3'd3;
  localparam state_t ST_EX1   = 3'd4;
  localparam state_t ST_EX2   = 3'd5;
  localparam state_t ST_EX3   = 3'd6;
  localparam state_t ST_FAULT = 3'd7;

  // Sensor code is {sens_a, sens_b}
  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_A    = 2'b10;
  localparam logic [1:0] S_AB   = 2'b11;

  localparam int DEFAULT_CAPACITY = 8;

endpackage

// File: rtl/parking_occupancy_counter.sv
// Saturating occupancy counter with registered entry/exit/reject strobes.
// full and empty are decoded from the count register.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEFAULT_CAPACITY,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             inc_done,
  output logic             dec_done,
  output logic             reject
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic [CNT_W-1:0] occ_q;

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] v,
                                                 input logic up,
                                                 input logic down);
    if (up && (v != CAP)) return v + 1'b1;
    if (down && (v != '0)) return v - 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= '0;
      inc_done <= 1'b0;
      dec_done <= 1'b0;
      reject   <= 1'b0;
    end else begin
      occ_q    <= sat_step(occ_q, inc, dec);
      inc_done <= inc && !full;
      dec_done <= dec && !empty;
      reject   <= (inc && full) || (dec && empty);
    end
  end

  assign occupancy = occ_q;
  assign full      = (occ_q == CAP);
  assign empty     = (occ_q == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Direction-sensing lane controller: decodes beam order into entry/exit events.
// Optional dwell timeout enabled by defining PARKING_TIMEOUT_EN.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEFAULT_CAPACITY,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = 24_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sens_a,
  input  logic             sens_b,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             enter_pulse,
  output logic             exit_pulse,
  output logic             reject,
  output logic             fault
);

  if ((CAPACITY < 1) || (CAPACITY > (1 << CNT_W) - 1) || (TIMEOUT < 1)) begin : g_param_check
    $error("parking_gate_ctrl: CAPACITY or TIMEOUT out of range");
  end

  logic [1:0] code;
  state_t     state, state_nxt, state_seq;
  logic       timed_out;
  logic       inc, dec;

  assign code = {sens_a, sens_b};

  always_comb begin
    state_seq = state;
    case (state)
      ST_IDLE: case (code)
        S_A:     state_seq = ST_EN1;
        S_B:     state_seq = ST_EX1;
        S_AB:    state_seq = ST_FAULT;
        default: state_seq = ST_IDLE;
      endcase
      ST_EN1: case (code)
        S_AB:    state_seq = ST_EN2;
        S_NONE:  state_seq = ST_IDLE;
        S_B:     state_seq = ST_FAULT;
        default: state_seq = ST_EN1;
      endcase
      ST_EN2: case (code)
        S_B:     state_seq = ST_EN3;
        S_A:     state_seq = ST_EN1;
        S_NONE:  state_seq = ST_FAULT;
        default: state_seq = ST_EN2;
      endcase
      ST_EN3: case (code)
        S_NONE:  state_seq = ST_IDLE;
        S_AB:    state_seq = ST_EN2;
        S_A:     state_seq = ST_FAULT;
        default: state_seq = ST_EN3;
      endcase
      ST_EX1: case (code)
        S_AB:    state_seq = ST_EX2;
        S_NONE:  state_seq = ST_IDLE;
        S_A:     state_seq = ST_FAULT;
        default: state_seq = ST_EX1;
      endcase
      ST_EX2: case (code)
        S_A:     state_seq = ST_EX3;
        S_B:     state_seq = ST_EX1;
        S_NONE:  state_seq = ST_FAULT;
        default: state_seq = ST_EX2;
      endcase
      ST_EX3: case (code)
        S_NONE:  state_seq = ST_IDLE;
        S_AB:    state_seq = ST_EX2;
        S_B:     state_seq = ST_FAULT;
        default: state_seq = ST_EX3;
      endcase
      default: state_seq = (code == S_NONE) ? ST_IDLE : ST_FAULT;
    endcase
  end

`ifdef PARKING_TIMEOUT_EN
  localparam int DW = $clog2(TIMEOUT + 1);
  logic [DW-1:0] dwell;
  logic          in_seq;

  assign in_seq    = (state != ST_IDLE) && (state != ST_FAULT);
  assign timed_out = in_seq && (dwell == DW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || !in_seq || (state_nxt != state)) dwell <= '0;
    else                                        dwell <= dwell + 1'b1;
  end
`else
  assign timed_out = 1'b0;
`endif

  // A timeout overrides any sequence step, including a pending commit
  assign state_nxt = timed_out ? ST_FAULT : state_seq;
  assign inc       = (state == ST_EN3) && (state_nxt == ST_IDLE);
  assign dec       = (state == ST_EX3) && (state_nxt == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  assign fault = (state == ST_FAULT);

  parking_occupancy_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc),
    .dec       (dec),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .inc_done  (enter_pulse),
    .dec_done  (exit_pulse),
    .reject    (reject)
  );

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: path-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_parking_gate_ctrl;

  localparam int CAP   = 8;
  localparam int CNT_W = 4;
`ifdef PARKING_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 24_000_000;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             sens_a, sens_b;
  logic [CNT_W-1:0] occupancy;
  logic             full, empty, enter_pulse, exit_pulse, reject, fault;

  int n_checks = 0;
  int n_errors = 0;
  int n_enter = 0, n_exit = 0, n_rej = 0;

  always #5 clk = ~clk;

  parking_gate_ctrl #(.CAPACITY(CAP), .CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .sens_a      (sens_a),
    .sens_b      (sens_b),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty),
    .enter_pulse (enter_pulse),
    .exit_pulse  (exit_pulse),
    .reject      (reject),
    .fault       (fault)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a car walks a 4-step beam path; dir 0=idle 1=entering 2=exiting 3=fault,
  // k = number of path steps currently matched.
  function automatic int path_code(input int dir, input int i);
    int en[4] = '{2, 3, 1, 0};
    int ex[4] = '{1, 3, 2, 0};
    return (dir == 1) ? en[i] : ex[i];
  endfunction

  int   m_dir = 0, m_k = 0, m_occ = 0, m_dwell = 0;
  logic m_enter = 0, m_exit = 0, m_rej = 0;
  logic m_valid = 0;

  always @(posedge clk) begin : model
    int c, d, k, o, dw, pd, pk;
    logic en, ex, rj, to_hit;
    c = {30'd0, sens_a, sens_b};
    d = m_dir; k = m_k; o = m_occ; dw = m_dwell;
    en = 0; ex = 0; rj = 0;
    if (rst) begin
      d = 0; k = 0; o = 0; dw = 0;
    end else begin
      pd = d; pk = k;
      to_hit = 0;
`ifdef PARKING_TIMEOUT_EN
      to_hit = (d == 1 || d == 2) && (dw == TO);
`endif
      if (to_hit) begin
        d = 3; k = 0;
      end else if (d == 0) begin
        if (c == 2)      begin d = 1; k = 1; end
        else if (c == 1) begin d = 2; k = 1; end
        else if (c == 3) d = 3;
      end else if (d == 3) begin
        if (c == 0) d = 0;
      end else if (c == path_code(d, k - 1)) begin
        // holding the current step
      end else if (c == path_code(d, k)) begin
        if (k == 3) begin
          if (d == 1) begin
            if (o < CAP) begin o++; en = 1; end else rj = 1;
          end else begin
            if (o > 0) begin o--; ex = 1; end else rj = 1;
          end
          d = 0; k = 0;
        end else k++;
      end else if ((k == 1) ? (c == 0) : (c == path_code(d, k - 2))) begin
        if (k == 1) begin d = 0; k = 0; end else k--;
      end else begin
        d = 3; k = 0;
      end
      if (d != pd || k != pk || d == 0 || d == 3) dw = 0; else dw++;
    end
    m_dir <= d; m_k <= k; m_occ <= o; m_dwell <= dw;
    m_enter <= en; m_exit <= ex; m_rej <= rj;
    m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("occupancy", int'(occupancy), m_occ);
      check("full", int'(full), int'(m_occ == CAP));
      check("empty", int'(empty), int'(m_occ == 0));
      check("enter_pulse", int'(enter_pulse), int'(m_enter));
      check("exit_pulse", int'(exit_pulse), int'(m_exit));
      check("reject", int'(reject), int'(m_rej));
      check("fault", int'(fault), int'(m_dir == 3));
      if (enter_pulse) n_enter++;
      if (exit_pulse)  n_exit++;
      if (reject)      n_rej++;
    end
  end

  task automatic hold(input logic [1:0] c, input int n);
    sens_a = c[1];
    sens_b = c[0];
    repeat (n) @(negedge clk);
  endtask

  task automatic seq4(input logic [1:0] c0, c1, c2, c3, input int n);
    hold(c0, n); hold(c1, n); hold(c2, n); hold(c3, n);
  endtask

  task automatic clr_counts;
    #1;
    n_enter = 0; n_exit = 0; n_rej = 0;
  endtask

  initial begin
    rst = 1'b1; sens_a = 1'b0; sens_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_occupancy", int'(occupancy), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_pulses", int'({enter_pulse, exit_pulse, reject}), 0);
    rst = 1'b0;

    // Single entry
    clr_counts();
    hold(2'b00, 4); seq4(2'b10, 2'b11, 2'b01, 2'b00, 4);
    #1;
    check("entry_pulses", n_enter, 1);
    check("entry_occ", int'(occupancy), 1);
    check("entry_empty", int'(empty), 0);

    // Single exit
    clr_counts();
    seq4(2'b01, 2'b11, 2'b10, 2'b00, 4);
    #1;
    check("exit_pulses", n_exit, 1);
    check("exit_occ", int'(occupancy), 0);
    check("exit_empty", int'(empty), 1);

    // Car reverses out after reaching both beams
    clr_counts();
    seq4(2'b10, 2'b11, 2'b10, 2'b00, 3);
    #1;
    check("reverse_events", n_enter + n_exit + n_rej, 0);
    check("reverse_occ", int'(occupancy), 0);
    check("reverse_fault", int'(fault), 0);

    // Fill the lot, then one more entry is rejected
    for (int i = 0; i < CAP; i++) seq4(2'b10, 2'b11, 2'b01, 2'b00, 2);
    #1;
    check("fill_occ", int'(occupancy), 8);
    check("fill_full", int'(full), 1);
    clr_counts();
    seq4(2'b10, 2'b11, 2'b01, 2'b00, 2);
    #1;
    check("full_reject", n_rej, 1);
    check("full_no_enter", n_enter, 0);
    check("full_occ", int'(occupancy), 8);
    check("full_flag", int'(full), 1);

    // Empty the lot, then one more exit is rejected
    for (int i = 0; i < CAP; i++) seq4(2'b01, 2'b11, 2'b10, 2'b00, 2);
    clr_counts();
    seq4(2'b01, 2'b11, 2'b10, 2'b00, 2);
    #1;
    check("empty_reject", n_rej, 1);
    check("empty_no_exit", n_exit, 0);
    check("empty_occ", int'(occupancy), 0);

    // Both beams from idle is illegal; fault holds until clear
    hold(2'b00, 2); hold(2'b11, 5);
    #1 check("fault_set", int'(fault), 1);
    hold(2'b01, 3);
    #1 check("fault_hold", int'(fault), 1);
    hold(2'b00, 1);
    #1 check("fault_clear", int'(fault), 0);

    // Illegal step within an entry (EN1 then lot beam only)
    hold(2'b10, 2); hold(2'b01, 2);
    #1 check("en1_illegal_fault", int'(fault), 1);
    hold(2'b00, 2);

    // Reset in EN2 abandons the car, then IDLE restarts on code 11 -> fault
    seq4(2'b10, 2'b11, 2'b01, 2'b00, 2);
    clr_counts();
    hold(2'b10, 2); hold(2'b11, 2);
    rst = 1'b1;
    hold(2'b11, 2);
    #1;
    check("mid_rst_occ", int'(occupancy), 0);
    check("mid_rst_empty", int'(empty), 1);
    check("mid_rst_fault", int'(fault), 0);
    check("mid_rst_enter", n_enter, 0);
    rst = 1'b0;
    hold(2'b11, 3);
    #1 check("post_rst_fault", int'(fault), 1);
    hold(2'b00, 2);

`ifdef PARKING_TIMEOUT_EN
    hold(2'b10, 20);
    #1 check("timeout_fault", int'(fault), 1);
    hold(2'b00, 2);
    #1 check("timeout_clear", int'(fault), 0);
`else
    hold(2'b10, 40);
    #1 check("no_timeout", int'(fault), 0);
    hold(2'b00, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
